// File: rtl/wb_slave_fabric.sv
// Wishbone single-master to N-slave fabric: address decode, lowest-index priority,
// combinational response return, locked bursts, decode-error and timeout aborts.
module wb_slave_fabric #(
  parameter int                         N_SLAVES    = 2,
  parameter int                         ADDR_W      = 32,
  parameter int                         DATA_W      = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE    = {32'h0000_1000, 32'h0000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK    = {32'hFFFF_F000, 32'hFFFF_F000},
  parameter int                         TIMEOUT_CYC = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ADDR_W-1:0]          m_addr_i,
  input  logic [DATA_W-1:0]          m_dat_i,
  output logic [DATA_W-1:0]          m_dat_o,
  input  logic                       m_we_i,
  input  logic [DATA_W/8-1:0]        m_sel_i,
  input  logic                       m_cyc_i,
  input  logic                       m_stb_i,
  input  logic                       m_lock_i,
  output logic                       m_ack_o,
  output logic                       m_err_o,
  output logic                       m_rty_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W-1:0]          s_dat_o,
  output logic                       s_we_o,
  output logic [DATA_W/8-1:0]        s_sel_o,
  output logic                       s_lock_o,
  output logic [N_SLAVES-1:0]        s_cyc_o,
  output logic [N_SLAVES-1:0]        s_stb_o,
  input  logic [N_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [N_SLAVES-1:0]        s_ack_i,
  input  logic [N_SLAVES-1:0]        s_err_i,
  input  logic [N_SLAVES-1:0]        s_rty_i,
  output logic [7:0]                 timeout_cnt_o,
  output logic [7:0]                 decode_err_cnt_o
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DERR = 2'd2,
    TOUT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
  logic [15:0]         tcnt_q, tcnt_d;
  logic [15:0]         tcnt_inc_s;
  logic [7:0]          tout_cnt_q, tout_cnt_d;
  logic [7:0]          derr_cnt_q, derr_cnt_d;
  logic [N_SLAVES-1:0] match_s;
  logic                hit_s;
  logic [IDX_W-1:0]    hit_idx_s;
  logic                sel_ack_s, sel_err_s, sel_rty_s;
  logic                resp_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign s_addr_o         = m_addr_i;
  assign s_dat_o          = m_dat_i;
  assign s_we_o           = m_we_i;
  assign s_sel_o          = m_sel_i;
  assign s_lock_o         = m_lock_i;
  assign timeout_cnt_o    = tout_cnt_q;
  assign decode_err_cnt_o = derr_cnt_q;

  // Address decode; descending scan so the lowest matching index wins
  always_comb begin
    hit_idx_s = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      match_s[i] = ((m_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                    (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]));
      hit_idx_s  = match_s[i] ? IDX_W'(i) : hit_idx_s;
    end
    hit_s = |match_s;
  end

  // Slave strobes and master response; only BUSY looks at slave responses
  always_comb begin
    s_cyc_o   = '0;
    s_stb_o   = '0;
    m_ack_o   = 1'b0;
    m_err_o   = 1'b0;
    m_rty_o   = 1'b0;
    m_dat_o   = '0;
    resp_s    = 1'b0;
    sel_ack_s = s_ack_i[sel_idx_q];
    sel_err_s = s_err_i[sel_idx_q];
    sel_rty_s = s_rty_i[sel_idx_q];
    case (state_q)
      BUSY: begin
        s_cyc_o[sel_idx_q] = m_cyc_i;
        s_stb_o[sel_idx_q] = m_stb_i;
        if (m_cyc_i && m_stb_i) begin
          m_err_o = sel_err_s;
          m_rty_o = ~sel_err_s & sel_rty_s;
          m_ack_o = ~sel_err_s & ~sel_rty_s & sel_ack_s;
          resp_s  = sel_err_s | sel_rty_s | sel_ack_s;
        end else begin
          resp_s  = 1'b0;
        end
        if (m_ack_o) begin
          m_dat_o = s_dat_i[int'(sel_idx_q)*DATA_W +: DATA_W];
        end else begin
          m_dat_o = '0;
        end
      end
      DERR, TOUT: m_err_o = 1'b1;
      default:    m_err_o = 1'b0;
    endcase
  end

  // Next-state, selected slave, timeout counter and abort statistics
  always_comb begin
    state_d    = state_q;
    sel_idx_d  = sel_idx_q;
    tcnt_d     = tcnt_q;
    tout_cnt_d = tout_cnt_q;
    derr_cnt_d = derr_cnt_q;
    tcnt_inc_s = tcnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (m_cyc_i && m_stb_i) begin
          if (hit_s) begin
            state_d   = BUSY;
            sel_idx_d = hit_idx_s;
          end else begin
            state_d   = DERR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!m_cyc_i) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end else if (resp_s) begin
          tcnt_d  = '0;
          state_d = m_lock_i ? BUSY : IDLE;
        end else begin
          tcnt_d  = tcnt_inc_s;
          state_d = (tcnt_inc_s == 16'(TIMEOUT_CYC)) ? TOUT : BUSY;
        end
      end
      DERR: begin
        state_d    = IDLE;
        derr_cnt_d = sat_inc8(derr_cnt_q);
      end
      TOUT: begin
        state_d    = IDLE;
        tcnt_d     = '0;
        tout_cnt_d = sat_inc8(tout_cnt_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sel_idx_q  <= '0;
      tcnt_q     <= '0;
      tout_cnt_q <= '0;
      derr_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_idx_q  <= sel_idx_d;
      tcnt_q     <= tcnt_d;
      tout_cnt_q <= tout_cnt_d;
      derr_cnt_q <= derr_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_slave_fabric.sv
// Directed plus randomized bench for wb_slave_fabric with a transaction-level reference model.
module tb_wb_slave_fabric;

  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [31:0] REF_BASE [NS] = '{32'h0000_0000, 32'h0000_1000};
  localparam logic [31:0] REF_MASK [NS] = '{32'hFFFF_F000, 32'hFFFF_F000};
  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] ACK  = 3'b100;
  localparam logic [2:0] ERR  = 3'b010;
  localparam logic [2:0] RTY  = 3'b001;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [AW-1:0]    m_addr_i;
  logic [DW-1:0]    m_dat_i;
  logic [DW-1:0]    m_dat_o;
  logic             m_we_i;
  logic [DW/8-1:0]  m_sel_i;
  logic             m_cyc_i;
  logic             m_stb_i;
  logic             m_lock_i;
  logic             m_ack_o;
  logic             m_err_o;
  logic             m_rty_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_dat_o;
  logic             s_we_o;
  logic [DW/8-1:0]  s_sel_o;
  logic             s_lock_o;
  logic [NS-1:0]    s_cyc_o;
  logic [NS-1:0]    s_stb_o;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i;
  logic [NS-1:0]    s_err_i;
  logic [NS-1:0]    s_rty_i;
  logic [7:0]       timeout_cnt_o;
  logic [7:0]       decode_err_cnt_o;

  int tests = 0;
  int fails = 0;
  int exp_derr = 0;
  int exp_tout = 0;

  wb_slave_fabric #(
    .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE({32'h0000_1000, 32'h0000_0000}),
    .SLV_MASK({32'hFFFF_F000, 32'hFFFF_F000}),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_addr_i(m_addr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_lock_i(m_lock_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_lock_o(s_lock_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .timeout_cnt_o(timeout_cnt_o), .decode_err_cnt_o(decode_err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observed vector: {s_cyc, s_stb, ack, err, rty, m_dat}
  task automatic expect_bus(input string tag, input logic [1:0] cyc, input logic [1:0] stb,
                            input logic [2:0] aer, input logic [31:0] dat);
    chk(tag, 64'({s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, m_dat_o}),
        64'({cyc, stb, aer, dat}));
  endtask

  task automatic expect_cnt(input string tag);
    chk(tag, 64'({timeout_cnt_o, decode_err_cnt_o}), 64'({8'(exp_tout), 8'(exp_derr)}));
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic quiet_master();
    m_cyc_i  = 1'b0;
    m_stb_i  = 1'b0;
    m_lock_i = 1'b0;
  endtask

  task automatic quiet_slaves();
    s_ack_i = '0;
    s_err_i = '0;
    s_rty_i = '0;
    s_dat_i = '0;
  endtask

  task automatic request(input logic [31:0] a, input logic we, input logic lock);
    m_addr_i = a;
    m_we_i   = we;
    m_lock_i = lock;
    m_cyc_i  = 1'b1;
    m_stb_i  = 1'b1;
    m_dat_i  = $urandom;
    m_sel_i  = 4'($urandom);
  endtask

  // Random responses on every slave except 'keep' (keep = -1 disturbs all)
  task automatic noise(input int keep);
    for (int i = 0; i < NS; i++) begin
      s_dat_i[i*DW +: DW] = $urandom;
      if (i == keep) begin
        s_ack_i[i] = 1'b0;
        s_err_i[i] = 1'b0;
        s_rty_i[i] = 1'b0;
      end else begin
        s_ack_i[i] = 1'($urandom);
        s_err_i[i] = 1'($urandom);
        s_rty_i[i] = 1'($urandom);
      end
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & REF_MASK[i]) == (REF_BASE[i] & REF_MASK[i])) return i;
    end
    return -1;
  endfunction

  function automatic int sat255(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  initial begin
    int          idx;
    int          lat;
    logic [2:0]  rsp;
    logic [2:0]  aer;
    logic [1:0]  oh;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_d;

    m_addr_i = '0; m_dat_i = '0; m_we_i = 1'b0; m_sel_i = '0;
    quiet_master();
    quiet_slaves();

    // Reset held with bus activity: everything quiet
    request(32'h0000_1004, 1'b0, 1'b0);
    s_ack_i = 2'b11; s_err_i = 2'b11;
    #1; expect_bus("reset.bus", 2'b00, 2'b00, NONE, 32'h0); expect_cnt("reset.cnt");
    tick(); #1; expect_bus("reset.hold", 2'b00, 2'b00, NONE, 32'h0);
    tick(); quiet_master(); quiet_slaves(); rst_i = 1'b0;

    // Read slave 1, ack two cycles after its strobe
    tick(); request(32'h0000_1004, 1'b0, 1'b0);
    #1; expect_bus("rd.t0", 2'b00, 2'b00, NONE, 32'h0);
    tick(); #1; expect_bus("rd.t1", 2'b10, 2'b10, NONE, 32'h0);
    tick(); #1; expect_bus("rd.t2", 2'b10, 2'b10, NONE, 32'h0);
    tick(); s_ack_i = 2'b10; s_dat_i = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    #1; expect_bus("rd.t3", 2'b10, 2'b10, ACK, 32'hCAFE_F00D);
    tick(); quiet_master(); quiet_slaves();
    #1; expect_bus("rd.t4", 2'b00, 2'b00, NONE, 32'h0);

    // Unmapped access
    tick(); request(32'h0000_2000, 1'b1, 1'b0);
    #1; expect_bus("derr.t0", 2'b00, 2'b00, NONE, 32'h0);
    tick(); noise(-1);
    #1; expect_bus("derr.t1", 2'b00, 2'b00, ERR, 32'h0);
    exp_derr = sat255(exp_derr);
    tick(); quiet_master(); quiet_slaves();
    #1; expect_bus("derr.t2", 2'b00, 2'b00, NONE, 32'h0); expect_cnt("derr.cnt");

    // Slave 0 silent: timeout after TO busy cycles, late ack ignored
    tick(); request(32'h0000_0040, 1'b0, 1'b0);
    #1; expect_bus("tout.t0", 2'b00, 2'b00, NONE, 32'h0);
    for (int k = 1; k <= TO; k++) begin
      tick(); #1; expect_bus("tout.busy", 2'b01, 2'b01, NONE, 32'h0);
    end
    tick(); s_ack_i = 2'b01;
    #1; expect_bus("tout.err", 2'b00, 2'b00, ERR, 32'h0);
    exp_tout = sat255(exp_tout);
    tick(); quiet_master();
    #1; expect_bus("tout.late", 2'b00, 2'b00, NONE, 32'h0); expect_cnt("tout.cnt");
    tick(); quiet_slaves();

    // Err and ack together from slave 1
    tick(); request(32'h0000_1000, 1'b0, 1'b0);
    #1; expect_bus("prio.t0", 2'b00, 2'b00, NONE, 32'h0);
    tick(); s_err_i = 2'b10; s_ack_i = 2'b10; s_dat_i = {32'h1234_5678, 32'h0};
    #1; expect_bus("prio.t1", 2'b10, 2'b10, ERR, 32'h0);
    tick(); quiet_master(); quiet_slaves();
    #1; expect_bus("prio.t2", 2'b00, 2'b00, NONE, 32'h0);

    // Locked burst of three strobes to slave 0 with a strobe gap
    tick(); request(32'h0000_0010, 1'b1, 1'b1);
    #1; expect_bus("lock.t0", 2'b00, 2'b00, NONE, 32'h0);
    tick(); s_ack_i = 2'b01; s_dat_i = {32'h0, 32'h1111_0001};
    #1; expect_bus("lock.a1", 2'b01, 2'b01, ACK, 32'h1111_0001);
    tick(); m_stb_i = 1'b0; quiet_slaves();
    #1; expect_bus("lock.gap", 2'b01, 2'b00, NONE, 32'h0);
    tick(); m_stb_i = 1'b1; s_ack_i = 2'b01; s_dat_i = {32'h0, 32'h1111_0002};
    #1; expect_bus("lock.a2", 2'b01, 2'b01, ACK, 32'h1111_0002);
    tick(); s_dat_i = {32'h0, 32'h1111_0003};
    #1; expect_bus("lock.a3", 2'b01, 2'b01, ACK, 32'h1111_0003);
    tick(); quiet_master(); quiet_slaves();
    #1; expect_bus("lock.end", 2'b00, 2'b00, NONE, 32'h0);
    tick(); #1; expect_bus("lock.idle", 2'b00, 2'b00, NONE, 32'h0);

    // Strobe held after a response is a fresh request
    tick(); request(32'h0000_1008, 1'b0, 1'b0);
    tick(); s_ack_i = 2'b10; s_dat_i = {32'hA5A5_0001, 32'h0};
    #1; expect_bus("hold.a1", 2'b10, 2'b10, ACK, 32'hA5A5_0001);
    tick(); quiet_slaves();
    #1; expect_bus("hold.idle", 2'b00, 2'b00, NONE, 32'h0);
    tick(); #1; expect_bus("hold.busy", 2'b10, 2'b10, NONE, 32'h0);
    tick(); s_ack_i = 2'b10; s_dat_i = {32'hA5A5_0002, 32'h0};
    #1; expect_bus("hold.a2", 2'b10, 2'b10, ACK, 32'hA5A5_0002);
    tick(); quiet_master(); quiet_slaves();

    // Reset in the middle of a BUSY cycle, then a normal request
    tick(); request(32'h0000_1008, 1'b0, 1'b0);
    tick(); #1; expect_bus("rstb.busy", 2'b10, 2'b10, NONE, 32'h0);
    tick(); s_ack_i = 2'b10; s_dat_i = {32'h7777_7777, 32'h0}; rst_i = 1'b1;
    exp_derr = 0; exp_tout = 0;
    #1; expect_bus("rstb.bus", 2'b00, 2'b00, NONE, 32'h0); expect_cnt("rstb.cnt");
    tick(); rst_i = 1'b0; quiet_master(); quiet_slaves();
    tick(); request(32'h0000_0100, 1'b0, 1'b0);
    #1; expect_bus("rstb.t0", 2'b00, 2'b00, NONE, 32'h0);
    tick(); s_ack_i = 2'b01; s_dat_i = {32'h0, 32'h5EED_0001};
    #1; expect_bus("rstb.ack", 2'b01, 2'b01, ACK, 32'h5EED_0001);
    tick(); quiet_master(); quiet_slaves();

    // Randomized transactions against the reference model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0:       addr = 32'($urandom) & 32'h0000_0FFF;
        1:       addr = 32'h0000_1000 | (32'($urandom) & 32'h0000_0FFF);
        default: addr = 32'($urandom) | 32'h0000_2000;
      endcase
      idx   = ref_decode(addr);
      lat   = $urandom_range(0, 3);
      rsp   = 3'($urandom_range(1, 7));
      rdata = $urandom;
      tick(); request(addr, 1'($urandom), 1'b0); noise(-1);
      #1; expect_bus("rnd.req", 2'b00, 2'b00, NONE, 32'h0);
      chk("rnd.pass", 64'({s_addr_o, s_we_o, s_sel_o, s_lock_o}),
          64'({m_addr_i, m_we_i, m_sel_i, 1'b0}));
      chk("rnd.wdat", 64'(s_dat_o), 64'(m_dat_i));
      if (idx < 0) begin
        tick(); noise(-1);
        #1; expect_bus("rnd.derr", 2'b00, 2'b00, ERR, 32'h0);
        exp_derr = sat255(exp_derr);
      end else begin
        oh = 2'b01 << idx;
        if (lat == 3) begin
          for (int k = 1; k <= TO; k++) begin
            tick(); noise(idx);
            #1; expect_bus("rnd.wait", oh, oh, NONE, 32'h0);
          end
          tick(); noise(-1);
          #1; expect_bus("rnd.tout", 2'b00, 2'b00, ERR, 32'h0);
          exp_tout = sat255(exp_tout);
        end else begin
          for (int k = 1; k <= lat; k++) begin
            tick(); noise(idx);
            #1; expect_bus("rnd.wait", oh, oh, NONE, 32'h0);
          end
          tick(); noise(idx);
          s_ack_i[idx] = rsp[0]; s_rty_i[idx] = rsp[1]; s_err_i[idx] = rsp[2];
          s_dat_i[idx*DW +: DW] = rdata;
          if (rsp[2]) begin
            aer = ERR; exp_d = 32'h0;
          end else if (rsp[1]) begin
            aer = RTY; exp_d = 32'h0;
          end else begin
            aer = ACK; exp_d = rdata;
          end
          #1; expect_bus("rnd.resp", oh, oh, aer, exp_d);
        end
      end
      tick(); quiet_master(); noise(-1);
      #1; expect_bus("rnd.idle", 2'b00, 2'b00, NONE, 32'h0); expect_cnt("rnd.cnt");
    end
    tick(); quiet_slaves();

    // Decode-error counter saturates at 255
    for (int n = 0; n < 260; n++) begin
      tick(); request(32'h8000_0000, 1'b0, 1'b0);
      tick();
      tick(); quiet_master();
      exp_derr = sat255(exp_derr);
    end
    #1; expect_cnt("sat.cnt");
    chk("sat.derr", 64'(decode_err_cnt_o), 64'(8'hFF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_slave_fabric.md
WB_SLAVE_FABRIC -- requirements
Module: wb_slave_fabric

Interface
REQ-001 SHALL have parameter N_SLAVES, default 2: number of slave ports, 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width, multiple of 8.
REQ-004 SHALL have parameter SLV_BASE, default {32'h0000_1000, 32'h0000_0000}: per-slave base address; slot i is bits [i*ADDR_W +: ADDR_W].
REQ-005 SHALL have parameter SLV_MASK, default {32'hFFFF_F000, 32'hFFFF_F000}: per-slave decode mask, packed like SLV_BASE.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 255: number of BUSY cycles without a response before the fabric aborts the cycle; 1..65535.
REQ-007 SHALL have the following ports. There is one clock, clk_i, and rst_i is an asynchronous, active-high reset.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- m_addr_i  in  ADDR_W  master address
- m_dat_i  in  DATA_W  master write data
- m_dat_o  out  DATA_W  read data to master
- m_we_i  in  1  write enable
- m_sel_i  in  DATA_W/8  byte selects
- m_cyc_i  in  1  cycle
- m_stb_i  in  1  strobe
- m_lock_i  in  1  lock
- m_ack_o  out  1  acknowledge
- m_err_o  out  1  error
- m_rty_o  out  1  retry
- s_addr_o  out  ADDR_W  broadcast address
- s_dat_o  out  DATA_W  broadcast write data
- s_we_o  out  1  broadcast write enable
- s_sel_o  out  DATA_W/8  broadcast byte selects
- s_lock_o  out  1  broadcast lock
- s_cyc_o  out  N_SLAVES  per-slave cycle
- s_stb_o  out  N_SLAVES  per-slave strobe
- s_dat_i  in  N_SLAVES*DATA_W  slave read data, slot i = [i*DATA_W +: DATA_W]
- s_ack_i  in  N_SLAVES  per-slave acknowledge
- s_err_i  in  N_SLAVES  per-slave error
- s_rty_i  in  N_SLAVES  per-slave retry
- timeout_cnt_o  out  8  saturating count of timeout aborts
- decode_err_cnt_o  out  8  saturating count of unmapped accesses

Function
REQ-008 SHALL pass s_addr_o, s_dat_o, s_we_o, s_sel_o and s_lock_o combinationally from the corresponding master inputs.
REQ-009 Slave i SHALL match when (m_addr_i & MASK_i) == (BASE_i & MASK_i). When several slaves match, the lowest index SHALL win.
REQ-010 The FSM SHALL have the states IDLE, BUSY, DERR and TOUT, and SHALL reset to IDLE.
REQ-011 In IDLE with m_cyc_i & m_stb_i asserted: on a match, the fabric SHALL register sel_idx and go to BUSY; with no match, it SHALL go to DERR. No slave strobe SHALL be asserted in IDLE.
REQ-012 In BUSY, s_cyc_o[sel_idx] and s_stb_o[sel_idx] SHALL follow m_cyc_i and m_stb_i, and all other bits SHALL be 0. The first slave strobe therefore occurs one cycle after the master request.
REQ-013 In BUSY, the fabric SHALL pass the selected slave's response to the master combinationally, in the same cycle. Priority SHALL be err > rty > ack, and only one of m_ack_o, m_err_o and m_rty_o SHALL be asserted.
REQ-014 m_dat_o SHALL equal s_dat_i[sel_idx] when m_ack_o=1, and SHALL be 0 otherwise.
REQ-015 On any response in BUSY, the FSM SHALL go to IDLE.
- If m_lock_i=1 and m_cyc_i=1, it SHALL instead stay in BUSY with sel_idx kept, s_cyc_o[sel_idx] held high and s_stb_o following m_stb_i.
- The locked burst SHALL end when m_cyc_i falls.
REQ-016 In BUSY, m_cyc_i=0 SHALL abort to IDLE the next cycle with no master response, and SHALL clear the timeout counter.
REQ-017 The timeout counter SHALL be 16 bits, cleared on entry to BUSY and on every response, and SHALL increment on each BUSY cycle without a response. When it reaches TIMEOUT_CYC, the FSM SHALL go to TOUT.
REQ-018 In TOUT, the fabric SHALL drive m_err_o=1 for exactly one cycle with all s_stb_o and s_cyc_o at 0, then return to IDLE. It SHALL increment timeout_cnt_o, saturating at 255.
REQ-019 In DERR, the fabric SHALL drive m_err_o=1 for exactly one cycle with all s_stb_o and s_cyc_o at 0, then return to IDLE. It SHALL increment decode_err_cnt_o, saturating at 255.
REQ-020 A late slave response arriving in TOUT or IDLE SHALL be ignored.
REQ-021 A master that holds m_stb_i after a response SHALL be treated as a new request and decoded in IDLE.

Reset
REQ-022 Asserting rst_i SHALL immediately force the following, even mid-transaction:
- state=IDLE, sel_idx=0, timeout counter=0
- timeout_cnt_o=0, decode_err_cnt_o=0
- s_cyc_o=0, s_stb_o=0
- m_ack_o=0, m_err_o=0, m_rty_o=0, m_dat_o=0
REQ-023 The first request after rst_i deasserts SHALL be decoded normally.

Verification
REQ-024 Read at 0x0000_1004 with slave 1 acking 2 cycles after its strobe, returning 0xCAFEF00D -> s_stb_o=2'b10 from T+1, m_ack_o=1 at T+3, m_dat_o=0xCAFEF00D, s_stb_o[0] never asserted.
REQ-025 Access to 0x0000_2000 -> m_err_o=1 for exactly 1 cycle at T+1, s_stb_o=0 throughout, decode_err_cnt_o 0->1.
REQ-026 Slave 0 never responds, TIMEOUT_CYC=4 -> m_err_o pulses once after 4 BUSY cycles, timeout_cnt_o=1, a late s_ack_i[0] is ignored.
REQ-027 Slave 1 asserts s_err_i and s_ack_i in the same cycle -> m_err_o=1, m_ack_o=0, m_dat_o=0.
REQ-028 Locked burst of 3 strobes to slave 0 -> s_cyc_o[0] held high across all 3, 3 m_ack_o pulses, no IDLE cycle until m_cyc_i falls.
REQ-029 rst_i asserted during BUSY -> all outputs 0 in that cycle, counters 0, next request decoded correctly.
